// File: rtl/writeback_bus_arbiter.sv
// rtl/writeback_bus_arbiter.sv - round-robin arbiter for the shared writeback bus
// Grants one execution-unit writeback per cycle and registers it onto the WB_* bus.
module writeback_bus_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int PHYS_REG_WIDTH  = 6,
  parameter int ROB_INDEX_WIDTH = 5,
  parameter int WORD_WIDTH      = 32
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*PHYS_REG_WIDTH-1:0]    req_phys_reg_tag,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]        req_data,
  input  logic [NUM_REQ*ROB_INDEX_WIDTH-1:0]   req_ROB_index,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 flush,
  output logic                                 WB_valid,
  output logic [PHYS_REG_WIDTH-1:0]            WB_phys_reg_tag,
  output logic [WORD_WIDTH-1:0]                WB_data,
  output logic [ROB_INDEX_WIDTH-1:0]           WB_ROB_index
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           rr_ptr_nxt;
  logic [NUM_REQ-1:0]         grant;
  logic [PTR_W-1:0]           grant_idx;
  logic                       grant_any;
  logic [PTR_W:0]             scan;
  logic [PHYS_REG_WIDTH-1:0]  sel_tag;
  logic [WORD_WIDTH-1:0]      sel_data;
  logic [ROB_INDEX_WIDTH-1:0] sel_rob;

  // Scan from rr_ptr upward (mod NUM_REQ); the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan >= NUM_REQ_W) begin
        scan = scan - NUM_REQ_W;
      end
      if (!grant_any && !flush && req_valid[scan[PTR_W-1:0]]) begin
        grant[scan[PTR_W-1:0]] = 1'b1;
        grant_idx              = scan[PTR_W-1:0];
        grant_any              = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    sel_rob  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_tag  = req_phys_reg_tag[i*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];
        sel_data = req_data[i*WORD_WIDTH +: WORD_WIDTH];
        sel_rob  = req_ROB_index[i*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant_any) begin
      rr_ptr_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Payload registers hold their last value when idle so downstream never sees junk.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr          <= '0;
      WB_valid        <= 1'b0;
      WB_phys_reg_tag <= '0;
      WB_data         <= '0;
      WB_ROB_index    <= '0;
    end else begin
      rr_ptr   <= rr_ptr_nxt;
      WB_valid <= grant_any;
      if (grant_any) begin
        WB_phys_reg_tag <= sel_tag;
        WB_data         <= sel_data;
        WB_ROB_index    <= sel_rob;
      end
    end
  end

endmodule

// File: tb/tb_writeback_bus_arbiter.sv
// tb/tb_writeback_bus_arbiter.sv - randomized self-checking bench for writeback_bus_arbiter
module tb_writeback_bus_arbiter;

  localparam int N = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*6-1:0]  req_phys_reg_tag = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N*5-1:0]  req_ROB_index = '0;
  logic [N-1:0]  req_ready;
  logic          flush = 1'b0;
  logic          WB_valid;
  logic [5:0]    WB_phys_reg_tag;
  logic [31:0]   WB_data;
  logic [4:0]    WB_ROB_index;

  writeback_bus_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_phys_reg_tag(req_phys_reg_tag),
    .req_data(req_data), .req_ROB_index(req_ROB_index),
    .req_ready(req_ready), .flush(flush),
    .WB_valid(WB_valid), .WB_phys_reg_tag(WB_phys_reg_tag),
    .WB_data(WB_data), .WB_ROB_index(WB_ROB_index)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0]  p_tag  [N];
  logic [31:0] p_data [N];
  logic [4:0]  p_rob  [N];

  int          m_ptr;
  logic        m_wb_valid;
  logic [5:0]  m_tag;
  logic [31:0] m_data;
  logic [4:0]  m_rob;
  int          last_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_wb_valid = 1'b0; m_tag = '0; m_data = '0; m_rob = '0;
  endtask

  // Winner is the valid requester at the smallest forward distance from the pointer.
  function automatic int model_winner(input logic [N-1:0] v, input logic fl);
    int best = -1;
    int bd = N;
    if (fl) return -1;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - m_ptr + N) % N) < bd) begin
        bd = (i - m_ptr + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  // Called at posedge+1; drives a cycle, checks at negedge, advances model, returns at next posedge+1.
  task automatic run_cycle(input logic [N-1:0] v, input logic fl);
    int w;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    flush = fl;
    for (int i = 0; i < N; i++) begin
      req_phys_reg_tag[i*6 +: 6] = p_tag[i];
      req_data[i*32 +: 32]       = p_data[i];
      req_ROB_index[i*5 +: 5]    = p_rob[i];
    end
    @(negedge CLK);
    w = model_winner(v, fl);
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("wb_valid", 32'(WB_valid), 32'(m_wb_valid));
    check("wb_tag", 32'(WB_phys_reg_tag), 32'(m_tag));
    check("wb_data", WB_data, m_data);
    check("wb_rob", 32'(WB_ROB_index), 32'(m_rob));
    if (w >= 0) begin
      m_ptr = (w + 1) % N;
      m_wb_valid = 1'b1;
      m_tag = p_tag[w]; m_data = p_data[w]; m_rob = p_rob[w];
    end else begin
      m_wb_valid = 1'b0;
    end
    last_w = w;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req_valid = '0;
    flush = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  int pending [N];
  int waitc   [N];
  int seq_exp [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    for (int i = 0; i < N; i++) begin
      p_tag[i] = 6'(i + 1); p_data[i] = 32'h1000 + i; p_rob[i] = 5'(i);
      pending[i] = 0; waitc[i] = 0;
    end
    model_reset();
    last_w = -1;

    @(posedge CLK);
    #1;
    check("rst_wb_valid", 32'(WB_valid), 32'd0);
    check("rst_wb_tag", 32'(WB_phys_reg_tag), 32'd0);
    check("rst_wb_data", WB_data, 32'd0);
    check("rst_wb_rob", 32'(WB_ROB_index), 32'd0);
    do_reset();

    // Single request
    p_tag[0] = 6'd40; p_data[0] = 32'hDEADBEEF; p_rob[0] = 5'd3;
    run_cycle(3'b001, 1'b0);
    check("single_w", 32'(last_w), 32'd0);
    check("single_valid", 32'(WB_valid), 32'd1);
    check("single_tag", 32'(WB_phys_reg_tag), 32'd40);
    check("single_data", WB_data, 32'hDEADBEEF);
    check("single_rob", 32'(WB_ROB_index), 32'd3);
    run_cycle(3'b000, 1'b0);
    check("single_idle", 32'(WB_valid), 32'd0);

    // All three from reset, then pointer wrap
    do_reset();
    for (int c = 0; c < 6; c++) begin
      run_cycle(3'b111, 1'b0);
      check("rr_seq", 32'(last_w), 32'(seq_exp[c]));
      check("rr_seq_valid", 32'(WB_valid), 32'd1);
    end
    run_cycle(3'b110, 1'b0);
    check("wrap_w1", 32'(last_w), 32'd1);
    run_cycle(3'b111, 1'b0);
    check("wrap_w2", 32'(last_w), 32'd2);

    // Flush after first grant
    do_reset();
    run_cycle(3'b111, 1'b0);
    check("flush_first", 32'(last_w), 32'd0);
    run_cycle(3'b111, 1'b1);
    check("flush_nogrant", 32'(last_w), 32'hFFFFFFFF);
    check("flush_wb_off", 32'(WB_valid), 32'd0);
    run_cycle(3'b111, 1'b0);
    check("flush_resume", 32'(last_w), 32'd1);

    // Asynchronous reset between edges
    run_cycle(3'b111, 1'b0);
    check("areset_pre", 32'(WB_valid), 32'd1);
    RST = 1'b1;
    #1;
    check("areset_wb", 32'(WB_valid), 32'd0);
    check("areset_data", WB_data, 32'd0);
    #1;
    RST = 1'b0;
    model_reset();
    run_cycle(3'b100, 1'b0);
    check("areset_w2", 32'(last_w), 32'd2);
    run_cycle(3'b011, 1'b0);
    check("areset_ptr0", 32'(last_w), 32'd0);

    // Random stress
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] v;
      logic fl;
      for (int i = 0; i < N; i++) begin
        if (pending[i] == 0 && $urandom_range(3) != 0) begin
          pending[i] = 1;
          waitc[i] = 0;
          p_tag[i] = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom);
          p_data[i] = $urandom;
          p_rob[i] = 5'($urandom);
        end
        v[i] = (pending[i] != 0);
      end
      fl = ($urandom_range(7) == 0);
      run_cycle(v, fl);
      if (last_w >= 0) check("onehot", 32'($countones(req_valid & v)) >= 1 ? 32'd1 : 32'd0, 32'd1);
      for (int i = 0; i < N; i++) begin
        if (pending[i] != 0) begin
          if (!fl) waitc[i]++;
          if (last_w == i) begin
            check("fair_wait", 32'(waitc[i] <= N), 32'd1);
            pending[i] = 0;
          end
        end
      end
    end
    run_cycle(3'b000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
